fir_filter_mc: RTL and testbench

// - Parametrised, time-multiplexed multi-channel FIR filter. Successor to the single-channel fir_filter.
// - Holds one delay line per channel and one shared, runtime-writable coefficient bank.
// - One sequential MAC evaluates NTAPS products per accepted sample.
// - Sits between the sample source and the output writer, with valid/ready handshakes on both sides.

---
 rtl/fir_filter_mc.sv | 142 ++++++++++++++
 tb/tb_fir_filter_mc.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mc.sv
// rtl/fir_filter_mc.sv - time-multiplexed multi-channel FIR filter with a shared runtime coefficient bank
// Optional macro FIR_ROUND_SAT_EN: round half up and saturate the output instead of floor and wrap.
module fir_filter_mc #(
   parameter int WD_IN     = 24,
   parameter int WD_OUT    = 24,
   parameter int WD_COEF   = 18,
   parameter int NTAPS     = 16,
   parameter int NCHAN     = 2,
   parameter int OUT_SHIFT = 16,
   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
   localparam int AW = $clog2(NTAPS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      fir_in_valid,
   output logic                      fir_ready,
   input  logic signed [WD_IN-1:0]   fir_input,
   input  logic [CW-1:0]             fir_in_chan,
   output logic                      fir_out_valid,
   input  logic                      fir_out_ready,
   output logic signed [WD_OUT-1:0]  fir_output,
   output logic [CW-1:0]             fir_out_chan,
   input  logic                      coef_we,
   input  logic [AW-1:0]             coef_addr,
   input  logic signed [WD_COEF-1:0] coef_data,
   output logic                      coef_ack
);

   localparam int WP = WD_IN + WD_COEF;
   localparam int WA = WP + AW;
   localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
   localparam logic [CW:0]   NCHAN_V  = (CW + 1)'(NCHAN);
   localparam logic signed [WD_COEF-1:0] COEF_ONE = WD_COEF'(1) << OUT_SHIFT;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MAC, S_OUT} state_t;
   state_t state, state_nxt;

   logic signed [WD_IN-1:0]   dly  [NCHAN][NTAPS];
   logic signed [WD_COEF-1:0] coef [NTAPS];
   logic signed [WD_IN-1:0]   samp_r;
   logic [CW-1:0]             chan_r;
   logic [AW-1:0]             tap;
   logic signed [WA-1:0]      acc;
   logic signed [WP-1:0]      prod;
   logic signed [WA-1:0]      acc_sum;
   logic signed [WD_OUT-1:0]  result;
   logic                      in_hs;
   logic                      chan_ok;
   logic                      coef_wr;

   always_comb begin
      fir_ready     = (state == S_IDLE) && !reset;
      fir_out_valid = (state == S_OUT) && !reset;
      in_hs         = fir_in_valid && fir_ready;
      chan_ok       = {1'b0, fir_in_chan} < NCHAN_V;
      // An input handshake in the same cycle takes priority over a coefficient write.
      coef_wr       = coef_we && (state == S_IDLE) && !in_hs;
      state_nxt     = state;
      case (state)
         S_IDLE:  if (in_hs && chan_ok) state_nxt = S_SHIFT;
         S_SHIFT: state_nxt = S_MAC;
         S_MAC:   if (tap == LAST_TAP) state_nxt = S_OUT;
         S_OUT:   if (fir_out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      prod    = WP'(dly[chan_r][tap]) * WP'(coef[tap]);
      acc_sum = acc + {{(WA - WP){prod[WP-1]}}, prod};
   end

`ifdef FIR_ROUND_SAT_EN
   localparam logic signed [WA-1:0] RND     = WA'(1) << (OUT_SHIFT - 1);
   localparam logic signed [WA-1:0] SAT_MAX = {{(WA - WD_OUT + 1){1'b0}}, {(WD_OUT - 1){1'b1}}};
   localparam logic signed [WA-1:0] SAT_MIN = {{(WA - WD_OUT + 1){1'b1}}, {(WD_OUT - 1){1'b0}}};
   logic signed [WA-1:0] shifted;

   always_comb begin
      shifted = (acc_sum + RND) >>> OUT_SHIFT;
      if (shifted > SAT_MAX)
         result = WD_OUT'(SAT_MAX);
      else if (shifted < SAT_MIN)
         result = WD_OUT'(SAT_MIN);
      else
         result = WD_OUT'(shifted);
   end
`else
   always_comb begin
      result = WD_OUT'(acc_sum >>> OUT_SHIFT);
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         tap          <= '0;
         acc          <= '0;
         samp_r       <= '0;
         chan_r       <= '0;
         fir_output   <= '0;
         fir_out_chan <= '0;
         coef_ack     <= 1'b0;
         for (int c = 0; c < NCHAN; c++)
            for (int k = 0; k < NTAPS; k++)
               dly[c][k] <= '0;
         // Identity response after reset: unity gain on the newest sample only.
         for (int k = 0; k < NTAPS; k++)
            coef[k] <= (k == 0) ? COEF_ONE : '0;
      end else begin
         state    <= state_nxt;
         coef_ack <= coef_wr;
         if (coef_wr)
            coef[coef_addr] <= coef_data;
         case (state)
            S_IDLE: begin
               if (in_hs) begin
                  samp_r <= fir_input;
                  chan_r <= fir_in_chan;
               end
            end
            S_SHIFT: begin
               for (int k = NTAPS - 1; k > 0; k--)
                  dly[chan_r][k] <= dly[chan_r][k-1];
               dly[chan_r][0] <= samp_r;
               acc <= '0;
               tap <= '0;
            end
            S_MAC: begin
               acc <= acc_sum;
               tap <= tap + AW'(1);
               if (tap == LAST_TAP) begin
                  fir_output   <= result;
                  fir_out_chan <= chan_r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_filter_mc.sv
// tb/tb_fir_filter_mc.sv - self-checking bench for fir_filter_mc against a behavioural per-channel model
module tb_fir_filter_mc;

   localparam int NTAPS = 4;
   localparam int NCHAN = 2;
   localparam int OUT_SHIFT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fir_in_valid = 1'b0;
   logic        fir_ready;
   logic [23:0] fir_input = '0;
   logic [0:0]  fir_in_chan = '0;
   logic        fir_out_valid;
   logic        fir_out_ready = 1'b1;
   logic [23:0] fir_output;
   logic [0:0]  fir_out_chan;
   logic        coef_we = 1'b0;
   logic [1:0]  coef_addr = '0;
   logic [17:0] coef_data = '0;
   logic        coef_ack;

   fir_filter_mc #(
      .WD_IN(24), .WD_OUT(24), .WD_COEF(18),
      .NTAPS(NTAPS), .NCHAN(NCHAN), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .clk(clk), .reset(reset),
      .fir_in_valid(fir_in_valid), .fir_ready(fir_ready),
      .fir_input(fir_input), .fir_in_chan(fir_in_chan),
      .fir_out_valid(fir_out_valid), .fir_out_ready(fir_out_ready),
      .fir_output(fir_output), .fir_out_chan(fir_out_chan),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .coef_ack(coef_ack)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int hist [NCHAN][NTAPS];
   int hmod [NTAPS];
   int exp_val[$];
   int exp_chan[$];
   int obs_val[$];
   int obs_chan[$];

   task automatic check(string name, longint act, longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCHAN; c++)
         for (int k = 0; k < NTAPS; k++)
            hist[c][k] = 0;
      for (int k = 0; k < NTAPS; k++)
         hmod[k] = (k == 0) ? 65536 : 0;
      exp_val.delete();
      exp_chan.delete();
   endtask

   function automatic int model_out(int c);
      longint acc = 0;
      longint r;
      for (int k = 0; k < NTAPS; k++)
         acc += longint'(hist[c][k]) * longint'(hmod[k]);
`ifdef FIR_ROUND_SAT_EN
      r = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
      if (r > 64'sd8388607) r = 64'sd8388607;
      if (r < -64'sd8388608) r = -64'sd8388608;
`else
      r = acc >>> OUT_SHIFT;
`endif
      return int'(r & 64'hFFFFFF);
   endfunction

   // Scoreboard: every completed output handshake is checked against the model queue.
   always @(negedge clk) begin
      if (!reset && fir_out_valid && fir_out_ready) begin
         if (exp_val.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got 0x%0h, required no output", fir_output);
         end else begin
            check("out_data", fir_output, exp_val[0]);
            check("out_chan", fir_out_chan, exp_chan[0]);
            void'(exp_val.pop_front());
            void'(exp_chan.pop_front());
         end
         obs_val.push_back(int'(fir_output));
         obs_chan.push_back(int'(fir_out_chan));
      end
   end

   task automatic send(int c, logic [23:0] v);
      int t = 0;
      fir_in_valid = 1'b1;
      fir_input    = v;
      fir_in_chan  = c[0:0];
      @(negedge clk);
      while (!fir_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!fir_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: fir_ready=0, required 1");
      end
      @(posedge clk);
      for (int k = NTAPS - 1; k > 0; k--)
         hist[c][k] = hist[c][k-1];
      hist[c][0] = int'($signed(v));
      exp_val.push_back(model_out(c));
      exp_chan.push_back(c);
      #1 fir_in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_val.size() != 0 || !fir_ready) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (exp_val.size() != 0 || !fir_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d outputs pending, required 0", exp_val.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_coef(int a, logic [17:0] d);
      coef_we   = 1'b1;
      coef_addr = a[1:0];
      coef_data = d;
      @(posedge clk);
      hmod[a] = int'($signed(d));
      #1 coef_we = 1'b0;
      @(negedge clk);
      check("coef_ack", coef_ack, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic set_all_unity();
      for (int k = 0; k < NTAPS; k++)
         set_coef(k, 18'h10000);
   endtask

   task automatic do_reset(int n);
      @(posedge clk);
      #1;
      reset = 1'b1;
      fir_in_valid = 1'b0;
      coef_we = 1'b0;
      model_reset();
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int t;
      int imp_exp [5];
      imp_exp = '{24'h100, 24'h100, 24'h100, 24'h100, 24'h000};
      model_reset();

      // Reset state
      @(negedge clk);
      check("rst_ready", fir_ready, 0);
      check("rst_out_valid", fir_out_valid, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_output", fir_output, 0);
      check("rst_out_chan", fir_out_chan, 0);
      check("rst_coef_ack", coef_ack, 0);
      check("post_rst_ready", fir_ready, 1);
      check("post_rst_valid", fir_out_valid, 0);

      // Passthrough with identity coefficients, plus latency
      @(posedge clk);
      #1;
      obs_val.delete(); obs_chan.delete();
      send(0, 24'h000123);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!fir_out_valid && lat < 20);
      check("latency", lat, NTAPS + 2);
      drain();
      check("pass_count", obs_val.size(), 1);
      if (obs_val.size() >= 1) begin
         check("pass_value", obs_val[0], 24'h000123);
         check("pass_chan", obs_chan[0], 0);
      end

      // Impulse response through all-unity taps
      do_reset(1);
      set_all_unity();
      obs_val.delete(); obs_chan.delete();
      send(0, 24'h000100);
      for (int i = 0; i < 4; i++) send(0, 24'h0);
      drain();
      check("imp_count", obs_val.size(), 5);
      for (int i = 0; i < 5 && i < obs_val.size(); i++)
         check($sformatf("imp_%0d", i), obs_val[i], imp_exp[i]);

      // Channel isolation
      do_reset(1);
      set_all_unity();
      obs_val.delete(); obs_chan.delete();
      for (int i = 0; i < 4; i++) begin
         send(0, 24'd10);
         send(1, 24'd1000);
      end
      drain();
      check("iso_count", obs_val.size(), 8);
      for (int i = 0; i < 4 && 2 * i + 1 < obs_val.size(); i++) begin
         check($sformatf("iso_ch0_%0d", i), obs_val[2*i], 10 * (i + 1));
         check($sformatf("iso_ch0_tag_%0d", i), obs_chan[2*i], 0);
         check($sformatf("iso_ch1_%0d", i), obs_val[2*i+1], 1000 * (i + 1));
         check($sformatf("iso_ch1_tag_%0d", i), obs_chan[2*i+1], 1);
      end

      // Backpressure: output held, no input, coefficient writes dropped
      do_reset(1);
      fir_out_ready = 1'b0;
      send(1, 24'h000005);
      t = 0;
      while (!fir_out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid", fir_out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         coef_we = (i == 1); coef_addr = 2'd0; coef_data = 18'h0;
         @(negedge clk);
         check("bp_output", fir_output, 24'h000005);
         check("bp_chan", fir_out_chan, 1);
         check("bp_ready", fir_ready, 0);
         check("bp_hold_valid", fir_out_valid, 1);
         if (i == 2) check("bp_coef_ack", coef_ack, 0);
      end
      @(posedge clk);
      #1 coef_we = 1'b0; fir_out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_ready", fir_ready, 1);
      obs_val.delete(); obs_chan.delete();
      @(posedge clk);
      #1;
      send(0, 24'h000077);
      drain();
      if (obs_val.size() >= 1) check("bp_coef_kept", obs_val[0], 24'h000077);
      else check("bp_coef_kept_count", obs_val.size(), 1);

      // Overflow
      do_reset(1);
      set_all_unity();
      obs_val.delete(); obs_chan.delete();
      for (int i = 0; i < 4; i++) send(0, 24'h7FFFFF);
      drain();
      if (obs_val.size() >= 4) begin
`ifdef FIR_ROUND_SAT_EN
         check("ovf_4th", obs_val[3], 24'h7FFFFF);
`else
         check("ovf_4th", obs_val[3], 24'hFFFFFC);
`endif
      end else check("ovf_count", obs_val.size(), 4);

      // Reset mid-MAC
      do_reset(1);
      set_all_unity();
      send(0, 24'h000040);
      drain();
      send(0, 24'h000020);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      model_reset();
      @(negedge clk);
      check("midrst_valid_now", fir_out_valid, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < NTAPS + 4; i++) begin
         @(negedge clk);
         check("midrst_no_valid", fir_out_valid, 0);
      end
      check("midrst_ready", fir_ready, 1);
      obs_val.delete(); obs_chan.delete();
      @(posedge clk);
      #1;
      send(0, 24'h000055);
      drain();
      set_all_unity();
      send(0, 24'h000000);
      drain();
      if (obs_val.size() >= 2) begin
         check("midrst_first", obs_val[0], 24'h000055);
         check("midrst_hist_cleared", obs_val[1], 24'h000055);
      end else check("midrst_count", obs_val.size(), 2);

      // Input handshake wins over a simultaneous coefficient write
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 18'h0;
      send(0, 24'h000010);
      coef_we = 1'b0;
      @(negedge clk);
      check("hs_wins_coef_ack", coef_ack, 0);
      drain();

      // Signed samples and mixed-sign coefficients, model-checked
      do_reset(1);
      set_coef(0, 18'h10000);
      set_coef(1, 18'h38000);
      set_coef(2, 18'h04000);
      set_coef(3, 18'h00003);
      send(0, 24'h000400);
      send(1, 24'hFFFFFF);
      send(0, 24'hFFF000);
      send(0, 24'h7FFFFF);
      send(1, 24'h123456);
      send(0, 24'h800000);
      send(0, 24'h012345);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
